// File: rtl/msk_pkg.sv
// Shared definitions for the masked share-refresh buffer: randomness width,
// share slicing and the FIFO occupancy encoding.
package msk_pkg;

   localparam int MSK_MAX_W     = 4096;
   localparam int MSK_MAX_COUNT = 256;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } fifo_state_e;

   function automatic int msk_rnd_width(input int d, input int count);
      return (d > 1) ? (d - 1) * count : 1;
   endfunction

   // Share i of a bus zero-extended to MSK_MAX_W, returned in the low count bits.
   function automatic logic [MSK_MAX_COUNT-1:0] msk_share(input logic [MSK_MAX_W-1:0] bus,
                                                         input int i, input int count);
      logic [MSK_MAX_COUNT-1:0] mask;
      mask = (count >= MSK_MAX_COUNT) ? '1 : ((MSK_MAX_COUNT'(1) << count) - 1'b1);
      return MSK_MAX_COUNT'(bus >> (i * count)) & mask;
   endfunction

endpackage

// File: rtl/msk_refresh_buf_if.sv
// Handshake bundle between the masked XOR layer, the refresh buffer and the next gadget.
interface msk_refresh_buf_if #(
   parameter int d     = 2,
   parameter int count = 32
);
   import msk_pkg::*;

   localparam int W  = count * d;
   localparam int RW = msk_rnd_width(d, count);

   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [RW-1:0] rnd;
   logic          rnd_valid;
   logic          rnd_ready;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output in_data, in_valid, rnd, rnd_valid, out_ready,
      input  in_ready, rnd_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, rnd, rnd_valid, out_ready,
      output in_ready, rnd_ready, out_data, out_valid
   );

endinterface

// File: rtl/msk_refresh_core.sv
// Combinational share refresh: shares 0..d-2 take one random word each, the last
// share absorbs the XOR of all words so the encoded value is unchanged.
module msk_refresh_core import msk_pkg::*; #(
   parameter int d     = 2,
   parameter int count = 32,
   localparam int RW   = msk_rnd_width(d, count)
) (
   input  logic [count*d-1:0] in,
   input  logic [RW-1:0]      rnd,
   output logic [count*d-1:0] out
);

   logic [count-1:0] acc;

   always_comb begin
      out = '0;
      acc = '0;
      for (int i = 0; i < d - 1; i++) begin
         out[i*count +: count] = in[i*count +: count] ^ rnd[i*count +: count];
         acc                   = acc ^ rnd[i*count +: count];
      end
      out[(d-1)*count +: count] = in[(d-1)*count +: count] ^ acc;
   end

endmodule

// File: rtl/msk_refresh_buf.sv
// Registered share-refresh stage: refresh on write, 2-entry FIFO, valid/ready on both sides.
// Outputs decode from registers only, giving a glitch barrier between gadgets.
module msk_refresh_buf import msk_pkg::*; #(
   parameter int d     = 2,
   parameter int count = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   msk_refresh_buf_if.slave  bus
);

   localparam int   W      = count * d;
   localparam logic SINGLE = (d == 1);

   fifo_state_e state_q, state_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [W-1:0] ent0_q, ent0_d;
   logic [W-1:0] ent1_q, ent1_d;
   logic [W-1:0] refreshed;
   logic        in_ready_w;
   logic        out_valid_w;
   logic        push;
   logic        pop;

   msk_refresh_core #(
      .d     (d),
      .count (count)
   ) u_core (
      .in  (bus.in_data),
      .rnd (bus.rnd),
      .out (refreshed)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         ent0_q   <= '0;
         ent1_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ent0_q   <= ent0_d;
         ent1_q   <= ent1_d;
      end
   end

   // Handshake decode; in_ready never sees out_ready, only the registered state.
   always_comb begin
      in_ready_w    = rst_n & (state_q != ST_FULL);
      out_valid_w   = (state_q != ST_EMPTY);
      push          = bus.in_valid & in_ready_w & (bus.rnd_valid | SINGLE);
      pop           = out_valid_w & bus.out_ready;
      bus.in_ready  = in_ready_w;
      bus.rnd_ready = bus.in_valid & in_ready_w & ~SINGLE;
      bus.out_valid = out_valid_w;
      bus.out_data  = rd_ptr_q ? ent1_q : ent0_q;
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      ent0_d   = ent0_q;
      ent1_d   = ent1_q;
      if (push && !wr_ptr_q) ent0_d = refreshed;
      if (push &&  wr_ptr_q) ent1_d = refreshed;
      case (state_q)
         ST_EMPTY: if (push)          state_d = ST_ONE;
         ST_ONE: begin
            if (push && !pop)         state_d = ST_FULL;
            else if (pop && !push)    state_d = ST_EMPTY;
         end
         ST_FULL:  if (pop)           state_d = ST_ONE;
         default:                     state_d = ST_EMPTY;
      endcase
   end

endmodule

// File: tb/tb_msk_refresh_buf.sv
// Scoreboard bench for msk_refresh_buf with d=2, d=3 and d=1 instances (count=4).
module tb_msk_refresh_buf;
   import msk_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [11:0] q2[$];
   logic [11:0] q3[$];
   logic [11:0] q1[$];

   msk_refresh_buf_if #(.d(2), .count(4)) if2 ();
   msk_refresh_buf_if #(.d(3), .count(4)) if3 ();
   msk_refresh_buf_if #(.d(1), .count(4)) if1 ();

   msk_refresh_buf #(.d(2), .count(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
   msk_refresh_buf #(.d(3), .count(4)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
   msk_refresh_buf #(.d(1), .count(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_checks++;
      $display("FAIL %s: got output %0h expected none", name, act);
   endtask

   function automatic logic [3:0] recomb(input logic [11:0] bus, input int d);
      logic [MSK_MAX_COUNT-1:0] sh;
      logic [3:0] x;
      x = '0;
      for (int i = 0; i < d; i++) begin
         sh = msk_share(MSK_MAX_W'(bus), i, 4);
         x  = x ^ sh[3:0];
      end
      return x;
   endfunction

   // Monitors: a handshake sampled on the falling edge fires on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && if2.out_valid && if2.out_ready) begin
         if (q2.size() == 0) unexpected("sb2_extra", 32'(if2.out_data));
         else chk("sb2_data", 32'(if2.out_data), 32'(q2.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (rst_n && if3.out_valid && if3.out_ready) begin
         if (q3.size() == 0) unexpected("sb3_extra", 32'(if3.out_data));
         else chk("sb3_data", 32'(if3.out_data), 32'(q3.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (rst_n && if1.out_valid && if1.out_ready) begin
         if (q1.size() == 0) unexpected("sb1_extra", 32'(if1.out_data));
         else chk("sb1_data", 32'(if1.out_data), 32'(q1.pop_front()));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive2(input logic [7:0] din, input logic [3:0] r, input logic iv, input logic rv);
      if2.in_data   = din;
      if2.rnd       = r;
      if2.in_valid  = iv;
      if2.rnd_valid = rv;
   endtask

   initial begin
      logic [7:0] sd;
      logic [3:0] s0, s1, rr;
      logic [3:0] v1 [5];

      drive2(8'h00, 4'h0, 1'b0, 1'b0);
      if2.out_ready = 1'b1;
      if3.in_data = '0; if3.rnd = '0; if3.in_valid = 1'b0; if3.rnd_valid = 1'b0; if3.out_ready = 1'b1;
      if1.in_data = '0; if1.rnd = '0; if1.in_valid = 1'b0; if1.rnd_valid = 1'b0; if1.out_ready = 1'b1;

      // Reset state, with in_valid high to show rnd_ready/in_ready are forced low.
      rst_n = 1'b0;
      repeat (3) cyc();
      drive2(8'h5A, 4'h3, 1'b1, 1'b0);
      #1;
      chk("rst_out_valid", 32'(if2.out_valid), 0);
      chk("rst_out_data",  32'(if2.out_data), 0);
      chk("rst_in_ready",  32'(if2.in_ready), 0);
      chk("rst_rnd_ready", 32'(if2.rnd_ready), 0);
      cyc();
      drive2(8'h00, 4'h0, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready",  32'(if2.in_ready), 1);
      chk("rel_rnd_ready", 32'(if2.rnd_ready), 0);
      chk("rel_out_valid", 32'(if2.out_valid), 0);

      // Basic refresh on all three configurations in the same cycle.
      drive2(8'h5A, 4'h3, 1'b1, 1'b1);
      q2.push_back(12'h069);
      if3.in_data = 12'h421; if3.rnd = 8'h53; if3.in_valid = 1'b1; if3.rnd_valid = 1'b1;
      q3.push_back(12'h272);
      if1.in_data = 4'h9; if1.rnd = 1'b1; if1.in_valid = 1'b1; if1.rnd_valid = 1'b1;
      q1.push_back(12'h009);
      #1;
      chk("basic_rnd_ready2", 32'(if2.rnd_ready), 1);
      chk("basic_rnd_ready1", 32'(if1.rnd_ready), 0);
      cyc();
      drive2(8'h00, 4'h0, 1'b0, 1'b0);
      if3.in_valid = 1'b0; if3.rnd_valid = 1'b0;
      if1.in_valid = 1'b0; if1.rnd_valid = 1'b0;
      #1;
      chk("basic_out_valid2", 32'(if2.out_valid), 1);
      chk("basic_out_data2",  32'(if2.out_data), 32'h69);
      chk("basic_recomb2",    32'(recomb(12'(if2.out_data), 2)), 32'hF);
      chk("basic_out_data3",  32'(if3.out_data), 32'h272);
      chk("basic_recomb3",    32'(recomb(if3.out_data, 3)), 32'h7);
      chk("basic_out_data1",  32'(if1.out_data), 32'h9);
      cyc();

      // Back-pressure: A then B fill the buffer, a third offer is refused.
      if2.out_ready = 1'b0;
      drive2(8'h12, 4'h1, 1'b1, 1'b1);
      q2.push_back(12'h003);
      cyc();
      chk("bp_in_ready_one", 32'(if2.in_ready), 1);
      drive2(8'h34, 4'hF, 1'b1, 1'b1);
      q2.push_back(12'h0CB);
      cyc();
      chk("bp_in_ready_full", 32'(if2.in_ready), 0);
      chk("bp_head",          32'(if2.out_data), 32'h03);
      drive2(8'h56, 4'h2, 1'b1, 1'b1);
      #1;
      chk("bp_rnd_ready_full", 32'(if2.rnd_ready), 0);
      repeat (2) begin
         cyc();
         chk("bp_hold_ready",  32'(if2.in_ready), 0);
         chk("bp_hold_data",   32'(if2.out_data), 32'h03);
         chk("bp_hold_valid",  32'(if2.out_valid), 1);
      end
      drive2(8'h00, 4'h0, 1'b0, 1'b0);
      if2.out_ready = 1'b1;
      cyc();
      chk("bp_ready_after_pop", 32'(if2.in_ready), 1);
      chk("bp_second_head",     32'(if2.out_data), 32'hCB);
      cyc();
      chk("bp_drained", 32'(if2.out_valid), 0);

      // Randomness starvation: nothing stored until rnd_valid rises.
      drive2(8'hA5, 4'h6, 1'b1, 1'b0);
      repeat (3) begin
         #1;
         chk("starve_rnd_ready", 32'(if2.rnd_ready), 1);
         cyc();
         chk("starve_no_push", 32'(if2.out_valid), 0);
      end
      if2.rnd_valid = 1'b1;
      q2.push_back(12'h0C3);
      cyc();
      drive2(8'h00, 4'h0, 1'b0, 1'b0);
      chk("starve_one_valid", 32'(if2.out_valid), 1);
      chk("starve_one_data",  32'(if2.out_data), 32'hC3);
      cyc();
      chk("starve_only_one", 32'(if2.out_valid), 0);

      // Streaming with simultaneous push and pop.
      for (int k = 0; k < 10; k++) begin
         s1 = 4'(k);
         s0 = 4'(15 - k);
         rr = 4'(k + 1);
         sd = {s1 ^ rr, s0 ^ rr};
         drive2({s1, s0}, rr, 1'b1, 1'b1);
         q2.push_back(12'(sd));
         cyc();
         chk("stream_not_full", 32'(if2.in_ready), 1);
         chk("stream_latency",  32'(if2.out_data), 32'(sd));
      end
      drive2(8'h00, 4'h0, 1'b0, 1'b0);
      cyc();
      chk("stream_drained", 32'(if2.out_valid), 0);

      // Reset with the buffer full drops both entries.
      if2.out_ready = 1'b0;
      drive2(8'hDE, 4'h7, 1'b1, 1'b1);
      cyc();
      drive2(8'hAD, 4'h9, 1'b1, 1'b1);
      cyc();
      drive2(8'h00, 4'h0, 1'b0, 1'b0);
      chk("rstmid_full", 32'(if2.in_ready), 0);
      rst_n = 1'b0;
      cyc();
      chk("rstmid_out_valid", 32'(if2.out_valid), 0);
      chk("rstmid_out_data",  32'(if2.out_data), 0);
      chk("rstmid_in_ready",  32'(if2.in_ready), 0);
      rst_n = 1'b1;
      if2.out_ready = 1'b1;
      repeat (3) begin
         cyc();
         chk("rstmid_no_stale", 32'(if2.out_valid), 0);
      end

      // d=1 pass-through: delayed by one cycle, rnd ignored.
      v1[0] = 4'h3; v1[1] = 4'hC; v1[2] = 4'h7; v1[3] = 4'hE; v1[4] = 4'h1;
      for (int k = 0; k < 5; k++) begin
         if1.in_data   = v1[k];
         if1.rnd       = 1'($urandom);
         if1.in_valid  = 1'b1;
         if1.rnd_valid = 1'($urandom);
         q1.push_back(12'(v1[k]));
         #1;
         chk("d1_rnd_ready", 32'(if1.rnd_ready), 0);
         cyc();
         chk("d1_delay", 32'(if1.out_data), 32'(v1[k]));
      end
      if1.in_valid = 1'b0;
      if1.rnd_valid = 1'b0;
      repeat (2) cyc();

      chk("sb2_empty", 32'(q2.size()), 0);
      chk("sb3_empty", 32'(q3.size()), 0);
      chk("sb1_empty", 32'(q1.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/msk_refresh_buf.md
# msk_refresh_buf

Registered share-refresh stage placed directly downstream of the masked XOR gates in the 32-bit masked AES datapath. It accepts `count` masked bits in `d` shares, re-randomises the sharing with fresh randomness, and holds the result in a 2-entry buffer behind a valid/ready handshake. This provides the register barrier that stops glitches from propagating between the linear layer and the next non-linear gadget. The encoded value (XOR of all shares) is never changed.

## Interface
- `d`, 2: number of shares; must be ≥ 1.
- `count`, 32: number of masked bits per transfer.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_data`  in  count*d: input sharing. Share i of bit j is at index i*count+j.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the buffer can accept an entry.
- `rnd`  in  RW: fresh randomness. RW = (d-1)*count when d > 1, else 1. Word k is `rnd[k*count +: count]`.
- `rnd_valid`  in  1: `rnd` is valid.
- `rnd_ready`  out  1: `rnd` is consumed this cycle.
- `out_data`  out  count*d: refreshed sharing, same layout as `in_data`.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: the consumer accepts `out_data`.

## Operation
- **Refresh rule, for d > 1:**
  - out_i = in_i ^ r_i for i < d-1.
  - out_{d-1} = in_{d-1} ^ r_0 ^ … ^ r_{d-2}.
- **Refresh rule, for d = 1:** plain registered pass-through. `rnd` is ignored and `rnd_ready` is held at 0.
- **Push:** push = in_valid & in_ready & (rnd_valid | d==1).
  - rnd_ready = in_valid & in_ready & (d > 1). Randomness is consumed only together with a data push.
  - If in_valid is high without rnd_valid, nothing is consumed and nothing is stored.
- **Pop:** pop = out_valid & out_ready.
- **Buffer:** 2-entry FIFO made of two registers, a read pointer, a write pointer and an occupancy count in {0, 1, 2}.
  - States: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - EMPTY -push-> ONE.
  - ONE -push & !pop-> FULL.
  - ONE -pop & !push-> EMPTY.
  - ONE -push & pop-> ONE. The pointers advance; the new entry is written while the old one is read.
  - FULL -pop-> ONE. No push can occur in FULL.
- **Handshake outputs:**
  - in_ready = !FULL, decoded from registered state only. There is no combinational path from out_ready to in_ready.
  - out_valid = !EMPTY.
  - out_data = the registered head entry. There is no combinational path from in_data or rnd to out_data.
- **Reset:** synchronous, active-low.
  - While rst_n = 0 at a clock edge: count ← 0, pointers ← 0, entry registers ← 0.
  - Pending entries are dropped. No handshake fires in that cycle.
  - `in_ready` is forced to 0 and `rnd_ready` to 0 while rst_n is low.
- **Encoding invariant:** XOR over all shares of out_data equals XOR over all shares of the corresponding in_data, bit by bit.
- **Value-independent control:** control never depends on share values. Any d = 1 configuration is unprotected and is used only for functional testing.

## Timing
- **Reset values:**
  - out_valid = 0.
  - out_data = 0.
  - in_ready = 1 from the first cycle after rst_n returns high.
  - rnd_ready = 0 until in_valid is asserted.
- **Latency:** one cycle. A push at edge N makes the data visible on out_data with out_valid = 1 after edge N.
- **Throughput:** one transfer per cycle when out_ready is held at 1.
  - Under back-pressure, at most 2 entries are held.
  - in_ready drops to 0 the cycle after the second entry is stored, and rises to 1 the cycle after a pop from FULL.
- **out_data stability:** out_data and out_valid stay stable while out_valid = 1 and out_ready = 0.
- **Pointer wrap-around:** pointers are 1 bit and wrap 1 → 0 without a penalty.

## Structure
- **Shared package `msk_pkg`:**
  - `msk_rnd_width(d, count)` function returning RW.
  - `msk_share(bus, i, count)` share-slice helper.
  - The FIFO occupancy state encoding.
- **Sub-module `msk_refresh_core`:** purely combinational refresh rule, ports `in`, `rnd`, `out`, same parameters. It is instantiated once, in front of the write port of the entry registers.
- **Top level:** `msk_refresh_buf` contains the FIFO control, the entry registers and the handshake logic.

## Test plan
- **d=2, count=4, basic refresh:**
  - Stimulus: after reset, in_data = 8'h5A (s1 = 5, s0 = A), rnd = 4'h3, all valids high, out_ready = 1.
  - Response: next cycle out_data = 8'h69 and out_valid = 1. Recombined value 4'hF.
- **d=3, count=4, three-share refresh:**
  - Stimulus: s0 = 1, s1 = 2, s2 = 4; r0 = 3, r1 = 5.
  - Response: out shares (2, 7, 2); recombined value 7 in both cases.
- **Back-pressure:**
  - Stimulus: out_ready = 0; push A then B.
  - Response: in_ready = 0 after the 2nd push and a 3rd in_valid is ignored. Raising out_ready pops A and then B in order, and in_ready returns to 1 one cycle after the first pop.
- **Randomness starvation:**
  - Stimulus: in_valid = 1, rnd_valid = 0 for 3 cycles.
  - Response: rnd_ready = 1, no push, count stays 0. When rnd_valid rises, exactly one entry is stored.
- **Simultaneous push and pop in ONE:**
  - Stimulus: out_ready = 1, new data every cycle for 10 cycles.
  - Response: 10 outputs in order, each 1 cycle after its input. Occupancy never reaches 2.
- **Reset mid-operation and d=1:**
  - Stimulus: pull rst_n low with the FIFO FULL.
  - Response: next cycle out_valid = 0 and out_data = 0; no stale entry appears after release.
  - For d = 1: out_data equals in_data delayed by one cycle, and rnd_ready stays 0 throughout.
